// File: rtl/sys_ctrl_pkg.sv
// Shared constants and types for the 2x2 systolic-array sequencer.
// Element packing: [DATA_W-1:0] = (0,0), then (0,1), (1,0), (1,1).
package sys_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int N          = 2;
  localparam int FEED_STEPS = 3;
  localparam int N_ELEM     = N * N;

  localparam int IDX_00 = 0;
  localparam int IDX_01 = 1;
  localparam int IDX_10 = 2;
  localparam int IDX_11 = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/sys_skew_sel.sv
// Picks the skewed operand wavefront {a1, a2, b1, b2} for one feed step.
// Purely combinational; any step outside 0..2 yields all zeros.
module sys_skew_sel
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [N_ELEM*DATA_W-1:0] a_mat_i,
  input  logic [N_ELEM*DATA_W-1:0] b_mat_i,
  input  logic [1:0]               step_i,
  output logic [DATA_W-1:0]        a1_o,
  output logic [DATA_W-1:0]        a2_o,
  output logic [DATA_W-1:0]        b1_o,
  output logic [DATA_W-1:0]        b2_o
);

  logic [DATA_W-1:0] a_el [N_ELEM];
  logic [DATA_W-1:0] b_el [N_ELEM];

  generate
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_unpack
      assign a_el[gi] = a_mat_i[gi*DATA_W +: DATA_W];
      assign b_el[gi] = b_mat_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Row 1 / column 1 lag one step behind row 0 / column 0.
  always_comb begin
    a1_o = '0;
    a2_o = '0;
    b1_o = '0;
    b2_o = '0;
    case (step_i)
      2'd0: begin
        a1_o = a_el[IDX_00];
        b1_o = b_el[IDX_00];
      end
      2'd1: begin
        a1_o = a_el[IDX_01];
        b1_o = b_el[IDX_10];
        a2_o = a_el[IDX_10];
        b2_o = b_el[IDX_01];
      end
      2'd2: begin
        a2_o = a_el[IDX_11];
        b2_o = b_el[IDX_11];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sys_array_ctrl.sv
// Job sequencer for the 2x2 output-stationary array: clear, skewed feed,
// drain, capture C and hand it off over a valid/ready result port.
module sys_array_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [N_ELEM*DATA_W-1:0] a_mat,
  input  logic [N_ELEM*DATA_W-1:0] b_mat,
  output logic                     arr_rst,
  output logic [DATA_W-1:0]        arr_a1,
  output logic [DATA_W-1:0]        arr_a2,
  output logic [DATA_W-1:0]        arr_b1,
  output logic [DATA_W-1:0]        arr_b2,
  input  logic [N_ELEM*DATA_W-1:0] arr_c,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [N_ELEM*DATA_W-1:0] res_c,
  output logic                     busy,
  output logic [15:0]              jobs_done
);

  localparam int MAT_W = N_ELEM * DATA_W;
  localparam logic [1:0] LAST_STEP  = 2'(FEED_STEPS - 1);
  localparam logic [3:0] LAST_DRAIN = 4'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [MAT_W-1:0] a_q, a_d;
  logic [MAT_W-1:0] b_q, b_d;
  logic [1:0]       step_q, step_d;
  logic [3:0]       drain_q, drain_d;
  logic             res_valid_q, res_valid_d;
  logic [MAT_W-1:0] res_c_q, res_c_d;
  logic [15:0]      jobs_q, jobs_d;

  logic              arr_rst_q, arr_rst_d;
  logic [DATA_W-1:0] arr_a1_q, arr_a1_d;
  logic [DATA_W-1:0] arr_a2_q, arr_a2_d;
  logic [DATA_W-1:0] arr_b1_q, arr_b1_d;
  logic [DATA_W-1:0] arr_b2_q, arr_b2_d;

  logic [DATA_W-1:0] sel_a1, sel_a2, sel_b1, sel_b2;
  logic              feed_next;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    step_d      = step_q;
    drain_d     = drain_q;
    res_valid_d = res_valid_q;
    res_c_d     = res_c_q;
    jobs_d      = jobs_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a_mat;
          b_d     = b_mat;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = FEED;
        step_d  = 2'd0;
      end
      FEED: begin
        if (step_q == LAST_STEP) begin
          state_d = DRAIN;
          drain_d = 4'd0;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_c_d     = arr_c;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          jobs_d      = jobs_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are registered from the next state so they line up with FEED cycles.
  sys_skew_sel #(
    .DATA_W (DATA_W)
  ) u_skew_sel (
    .a_mat_i (a_q),
    .b_mat_i (b_q),
    .step_i  (step_d),
    .a1_o    (sel_a1),
    .a2_o    (sel_a2),
    .b1_o    (sel_b1),
    .b2_o    (sel_b2)
  );

  always_comb begin
    feed_next = (state_d == FEED);
    arr_rst_d = (state_d == IDLE) || (state_d == CLEAR);
    arr_a1_d  = feed_next ? sel_a1 : '0;
    arr_a2_d  = feed_next ? sel_a2 : '0;
    arr_b1_d  = feed_next ? sel_b1 : '0;
    arr_b2_d  = feed_next ? sel_b2 : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      step_q      <= 2'd0;
      drain_q     <= 4'd0;
      res_valid_q <= 1'b0;
      res_c_q     <= '0;
      jobs_q      <= 16'd0;
      arr_rst_q   <= 1'b1;
      arr_a1_q    <= '0;
      arr_a2_q    <= '0;
      arr_b1_q    <= '0;
      arr_b2_q    <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      step_q      <= step_d;
      drain_q     <= drain_d;
      res_valid_q <= res_valid_d;
      res_c_q     <= res_c_d;
      jobs_q      <= jobs_d;
      arr_rst_q   <= arr_rst_d;
      arr_a1_q    <= arr_a1_d;
      arr_a2_q    <= arr_a2_d;
      arr_b1_q    <= arr_b1_d;
      arr_b2_q    <= arr_b2_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign arr_rst     = arr_rst_q;
  assign arr_a1      = arr_a1_q;
  assign arr_a2      = arr_a2_q;
  assign arr_b1      = arr_b1_q;
  assign arr_b2      = arr_b2_q;
  assign res_valid   = res_valid_q;
  assign res_c       = res_c_q;
  assign jobs_done   = jobs_q;

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Directed bench for sys_array_ctrl with a behavioural 2x2 output-stationary
// array attached to the operand/C ports.
module tb_sys_array_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [63:0] a_mat, b_mat;
  logic        arr_rst;
  logic [15:0] arr_a1, arr_a2, arr_b1, arr_b2;
  logic [63:0] arr_c;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_c;
  logic        busy;
  logic [15:0] jobs_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sys_array_ctrl #(.DATA_W(16), .DRAIN_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_mat       (a_mat),
    .b_mat       (b_mat),
    .arr_rst     (arr_rst),
    .arr_a1      (arr_a1),
    .arr_a2      (arr_a2),
    .arr_b1      (arr_b1),
    .arr_b2      (arr_b2),
    .arr_c       (arr_c),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_c       (res_c),
    .busy        (busy),
    .jobs_done   (jobs_done)
  );

  // Array model: each PE accumulates a*b and forwards a right / b down.
  logic [15:0] pc [4];
  logic [15:0] pe00_a, pe00_b, pe10_a, pe01_b;
  always @(posedge clk) begin
    if (arr_rst) begin
      for (int i = 0; i < 4; i++) pc[i] <= 16'd0;
      pe00_a <= 16'd0; pe00_b <= 16'd0; pe10_a <= 16'd0; pe01_b <= 16'd0;
    end else begin
      pc[0]  <= pc[0] + arr_a1 * arr_b1;
      pc[1]  <= pc[1] + pe00_a * arr_b2;
      pc[2]  <= pc[2] + arr_a2 * pe00_b;
      pc[3]  <= pc[3] + pe10_a * pe01_b;
      pe00_a <= arr_a1; pe00_b <= arr_b1; pe10_a <= arr_a2; pe01_b <= arr_b2;
    end
  end
  assign arr_c = {pc[3], pc[2], pc[1], pc[0]};

  function automatic logic [63:0] pack4(input logic [15:0] e00, e01, e10, e11);
    return {e11, e10, e01, e00};
  endfunction

  localparam logic [63:0] C1 = 64'h0032_002B_0016_0013;
  localparam logic [63:0] C2 = 64'h000C_000A_0008_0006;

  // Called at a negedge while IDLE; returns at the negedge of cycle k+1.
  task automatic start_job(input logic [63:0] a, input logic [63:0] b);
    a_mat = a;
    b_mat = b;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    while (!res_valid && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start_valid = 1'b0; res_ready = 1'b0; a_mat = '0; b_mat = '0;
    repeat (3) @(negedge clk);
    total++; if (arr_rst !== 1'b1) begin bad++; $display("FAIL reset_arr_rst got=%0b want=1", arr_rst); end
    total++; if ({arr_a1, arr_a2, arr_b1, arr_b2} !== 64'h0) begin bad++; $display("FAIL reset_ops got=%h want=0", {arr_a1, arr_a2, arr_b1, arr_b2}); end
    total++; if (res_valid !== 1'b0 || res_c !== 64'h0) begin bad++; $display("FAIL reset_res got=%0b/%h want=0/0", res_valid, res_c); end
    total++; if (jobs_done !== 16'h0 || busy !== 1'b0 || start_ready !== 1'b1) begin bad++; $display("FAIL reset_status got jobs=%h busy=%0b rdy=%0b want 0/0/1", jobs_done, busy, start_ready); end
    rst = 1'b1;
    @(negedge clk);
    $display("reset: jobs=%0d busy=%0b", jobs_done, busy);
  endtask

  task automatic test_basic;
    logic [63:0] exp_ops [3];
    exp_ops[0] = {16'd1, 16'd5, 16'd0, 16'd0};
    exp_ops[1] = {16'd2, 16'd7, 16'd3, 16'd6};
    exp_ops[2] = {16'd0, 16'd0, 16'd4, 16'd8};
    res_ready = 1'b1;
    start_job(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    total++; if (arr_rst !== 1'b1 || busy !== 1'b1 || start_ready !== 1'b0) begin bad++; $display("FAIL clear_cycle got rst=%0b busy=%0b rdy=%0b want 1/1/0", arr_rst, busy, start_ready); end
    total++; if ({arr_a1, arr_b1, arr_a2, arr_b2} !== 64'h0) begin bad++; $display("FAIL clear_ops got=%h want=0", {arr_a1, arr_b1, arr_a2, arr_b2}); end
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      total++; if (arr_rst !== 1'b0 || {arr_a1, arr_b1, arr_a2, arr_b2} !== exp_ops[s]) begin bad++; $display("FAIL feed_step%0d got rst=%0b ops=%h want 0/%h", s, arr_rst, {arr_a1, arr_b1, arr_a2, arr_b2}, exp_ops[s]); end
    end
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      total++; if ({arr_a1, arr_b1, arr_a2, arr_b2} !== 64'h0 || res_valid !== 1'b0) begin bad++; $display("FAIL drain%0d got ops=%h valid=%0b want 0/0", d, {arr_a1, arr_b1, arr_a2, arr_b2}, res_valid); end
    end
    @(negedge clk);
    total++; if (res_valid !== 1'b1 || res_c !== C1) begin bad++; $display("FAIL basic_result got valid=%0b c=%h want 1/%h", res_valid, res_c, C1); end
    @(negedge clk);
    total++; if (res_valid !== 1'b0 || jobs_done !== 16'd1 || start_ready !== 1'b1 || res_c !== C1) begin bad++; $display("FAIL basic_handoff got valid=%0b jobs=%0d rdy=%0b c=%h want 0/1/1/%h", res_valid, jobs_done, start_ready, res_c, C1); end
    $display("basic: res_c=%h jobs=%0d", res_c, jobs_done);
  endtask

  task automatic test_input_change;
    int n;
    res_ready = 1'b1;
    start_job(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    a_mat = {4{16'hFFFF}};
    wait_valid(20, n);
    total++; if (n !== 6 || res_c !== C1) begin bad++; $display("FAIL input_change got wait=%0d c=%h want 6/%h", n, res_c, C1); end
    @(negedge clk);
    total++; if (jobs_done !== 16'd2) begin bad++; $display("FAIL input_change_jobs got=%0d want=2", jobs_done); end
    $display("input_change: res_c=%h latency=%0d", res_c, n + 1);
  endtask

  task automatic test_backpressure;
    int n;
    int held_bad;
    res_ready = 1'b0;
    start_job(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    wait_valid(20, n);
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout got valid=%0b want=1", res_valid); end
    held_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (res_valid !== 1'b1 || res_c !== C1 || start_ready !== 1'b0 || jobs_done !== 16'd2) begin bad++; held_bad++; $display("FAIL bp_hold%0d got valid=%0b c=%h rdy=%0b jobs=%0d want 1/%h/0/2", i, res_valid, res_c, start_ready, jobs_done, C1); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    total++; if (res_valid !== 1'b0 || jobs_done !== 16'd3 || busy !== 1'b0) begin bad++; $display("FAIL bp_release got valid=%0b jobs=%0d busy=%0b want 0/3/0", res_valid, jobs_done, busy); end
    @(negedge clk);
    total++; if (jobs_done !== 16'd3) begin bad++; $display("FAIL bp_single_inc got=%0d want=3", jobs_done); end
    $display("backpressure: held_errs=%0d jobs=%0d", held_bad, jobs_done);
  endtask

  task automatic test_back_to_back;
    int n;
    res_ready = 1'b1;
    a_mat = pack4(1, 2, 3, 4);
    b_mat = pack4(5, 6, 7, 8);
    start_valid = 1'b1;
    @(negedge clk);
    a_mat = pack4(2, 0, 0, 2);
    b_mat = pack4(3, 4, 5, 6);
    wait_valid(20, n);
    total++; if (res_c !== C1 || n !== 6) begin bad++; $display("FAIL b2b_first got c=%h wait=%0d want %h/6", res_c, n, C1); end
    @(negedge clk);
    total++; if (start_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got rdy=%0b busy=%0b valid=%0b want 1/0/0", start_ready, busy, res_valid); end
    @(negedge clk);
    total++; if (busy !== 1'b1 || start_ready !== 1'b0 || arr_rst !== 1'b1) begin bad++; $display("FAIL b2b_reaccept got busy=%0b rdy=%0b arr_rst=%0b want 1/0/1", busy, start_ready, arr_rst); end
    start_valid = 1'b0;
    wait_valid(20, n);
    total++; if (res_c !== C2 || n !== 6) begin bad++; $display("FAIL b2b_second got c=%h wait=%0d want %h/6", res_c, n, C2); end
    @(negedge clk);
    total++; if (jobs_done !== 16'd5) begin bad++; $display("FAIL b2b_jobs got=%0d want=5", jobs_done); end
    $display("back_to_back: res_c=%h jobs=%0d", res_c, jobs_done);
  endtask

  task automatic test_reset_mid;
    int n;
    int seen;
    res_ready = 1'b1;
    start_job(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    total++; if (arr_rst !== 1'b1 || {arr_a1, arr_a2, arr_b1, arr_b2} !== 64'h0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_state got arr_rst=%0b ops=%h busy=%0b want 1/0/0", arr_rst, {arr_a1, arr_a2, arr_b1, arr_b2}, busy); end
    total++; if (jobs_done !== 16'd0 || res_c !== 64'h0) begin bad++; $display("FAIL midrst_regs got jobs=%0d c=%h want 0/0", jobs_done, res_c); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_result got valid_cycles=%0d want=0", seen); end
    start_job(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    wait_valid(20, n);
    total++; if (res_c !== C1) begin bad++; $display("FAIL midrst_rerun got=%h want=%h", res_c, C1); end
    @(negedge clk);
    // Reset coinciding with a handoff: reset wins.
    res_ready = 1'b0;
    start_job(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    wait_valid(20, n);
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    total++; if (jobs_done !== 16'd0 || res_valid !== 1'b0) begin bad++; $display("FAIL rst_vs_ready got jobs=%0d valid=%0b want 0/0", jobs_done, res_valid); end
    $display("reset_mid: jobs=%0d", jobs_done);
  endtask

  task automatic test_wrap;
    int n;
    res_ready = 1'b1;
    start_job(pack4(16'h8000, 0, 0, 0), pack4(2, 0, 0, 0));
    wait_valid(20, n);
    total++; if (res_valid !== 1'b1 || res_c !== 64'h0) begin bad++; $display("FAIL wrap_c got valid=%0b c=%h want 1/0", res_valid, res_c); end
    @(negedge clk);
    force dut.jobs_q = 16'hFFFF;
    @(negedge clk);
    release dut.jobs_q;
    @(negedge clk);
    total++; if (jobs_done !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h want=ffff", jobs_done); end
    start_job(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    wait_valid(20, n);
    @(negedge clk);
    total++; if (jobs_done !== 16'h0000 || res_c !== C1) begin bad++; $display("FAIL wrap_jobs got jobs=%h c=%h want 0000/%h", jobs_done, res_c, C1); end
    $display("wrap: jobs=%h", jobs_done);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_input_change();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sys_array_ctrl.md
Name: sys_array_ctrl

Overview:
Sequencer for the 2x2 output-stationary systolic array (`sys`). It accepts a pair of 2x2 16-bit matrices through a valid/ready handshake and clears the array accumulators. It then drives the skewed a1/a2/b1/b2 operand wavefront, waits for the array to drain, captures the four C outputs and presents them through a valid/ready result handshake. It sits between the host/testbench and `sys`, replacing hand-timed stimulus.

Parameters:
DATA_W, 16, operand/result element width (matches `sys`)
DRAIN_CYCLES, 2, cycles after the last feed step before C is sampled; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
start_valid  in  1  job request; A/B valid
start_ready  out  1  high only in IDLE
a_mat  in  4*DATA_W  A packed: [15:0]=A00, [31:16]=A01, [47:32]=A10, [63:48]=A11
b_mat  in  4*DATA_W  B, same packing
arr_rst  out  1  active-high clear to `sys` rst
arr_a1  out  DATA_W  array row-0 operand
arr_a2  out  DATA_W  array row-1 operand
arr_b1  out  DATA_W  array col-0 operand
arr_b2  out  DATA_W  array col-1 operand
arr_c  in  4*DATA_W  array C, same packing (c11, c12, c21, c22)
res_valid  out  1  res_c holds a completed product
res_ready  in  1  consumer accepts result
res_c  out  4*DATA_W  captured C, same packing
busy  out  1  state != IDLE
jobs_done  out  16  count of results handed off, wraps at 0xFFFF -> 0

Behaviour:
- Reset (rst == 0 at a rising edge) puts the block in IDLE. Outputs: arr_rst = 1, arr_a*/arr_b* = 0, res_valid = 0, res_c = 0, jobs_done = 0, busy = 0.
- Reset takes effect from any state. An in-flight job is dropped with no result.
- Job accept: start_valid && start_ready at edge k. a_mat and b_mat are latched into internal registers. Later changes on a_mat/b_mat do not affect the job.
- States:
  - IDLE -> CLEAR on accept.
  - CLEAR: 1 cycle, arr_rst = 1.
  - FEED: 3 cycles, step counter s = 0..2.
  - DRAIN: DRAIN_CYCLES cycles.
  - DONE: held until res_ready.
- arr_rst = 1 in IDLE and CLEAR, 0 in FEED, DRAIN and DONE. Operands are 0 outside FEED, so the accumulators hold in DONE.
- FEED schedule, as registered outputs:
  - s = 0: a1 = A00, b1 = B00, a2 = 0, b2 = 0
  - s = 1: a1 = A01, b1 = B10, a2 = A10, b2 = B01
  - s = 2: a1 = 0, b1 = 0, a2 = A11, b2 = B11
- Timing from accept edge k:
  - CLEAR is cycle k+1.
  - FEED is cycles k+2..k+4.
  - DRAIN is cycles k+5..k+4+DRAIN_CYCLES.
  - On the last DRAIN edge, arr_c is registered into res_c and res_valid rises.
  - Latency accept -> res_valid = 5 + DRAIN_CYCLES cycles (7 at default).
- The controller does no arithmetic. res_c is the array value verbatim (mod 2^16 wrap is the array's behaviour).
- DONE: res_valid = 1 and res_c is stable until res_valid && res_ready at an edge. That edge increments jobs_done and moves the block to IDLE. res_valid drops next cycle; res_c retains its value.
- res_ready asserted before DONE has no effect.
- No back-to-back overlap: start_ready is 0 from the accept edge until IDLE is re-entered. A start_valid held high during a job is accepted on the first IDLE cycle.
- Simultaneous reset and res_ready: reset wins, and jobs_done does not increment.

Decomposition:
- Package sys_ctrl_pkg holds: DATA_W default, N = 2, FEED_STEPS = 3, the state enum (IDLE, CLEAR, FEED, DRAIN, DONE), and pack/unpack index localparams for the 4-element packing.
- One sub-module, sys_skew_sel: combinational selection of {a1, a2, b1, b2} from the latched A, B and the step s. Zero for s outside 0..2.
- The FSM, counters and output registers live in sys_array_ctrl.

Test Plan:
- Basic job: A = [[1,2],[3,4]], B = [[5,6],[7,8]] with `sys` attached and res_ready = 1 -> res_valid at k+7. res_c = {0x0032, 0x002B, 0x0016, 0x0013} (C00 = 19, C01 = 22, C10 = 43, C11 = 50). jobs_done = 1.
- Skew check: same job -> arr_a1/arr_b1/arr_a2/arr_b2 equal (1,5,0,0), (2,7,3,6), (0,0,4,8) at cycles k+2..k+4. All zero elsewhere. arr_rst = 1 at k+1 and 0 at k+2.
- Backpressure: res_ready = 0 for 10 cycles after res_valid -> res_c stable, start_ready = 0, jobs_done unchanged. Raise res_ready -> one-cycle handoff, return to IDLE, jobs_done increments once.
- Input change: alter a_mat to all 0xFFFF at k+1 -> result still 19/22/43/50.
- Reset mid-job: drive rst = 0 at k+3 -> next cycle IDLE, arr_rst = 1, operands 0, res_valid never rises. A subsequent job gives correct C with the array accumulators cleared.
- Wrap: A = [[0x8000,0],[0,0]], B = [[2,0],[0,0]] -> C00 = 0x0000. Also preload jobs_done to 0xFFFF via 65535 fast jobs (or force) -> next handoff gives 0.
